keys_debounce: RTL
==================

KEYS_DEBOUNCE -- requirements
Module: keys_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable pclk cycles required to accept a new level (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of each per-bit stability counter; SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 pclk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 preset  input  1  synchronous, active-high reset.
REQ-005 key_raw  input  4  asynchronous board pushbuttons, active-low (0 = pressed).
REQ-006 sw_raw  input  10  asynchronous board slide switches.
REQ-007 key  output  4  debounced key level, same polarity as key_raw; feeds the POCI keys/switches peripheral.
REQ-008 sw  output  10  debounced switch level; feeds the POCI keys/switches peripheral.
REQ-009 key_press  output  4  one-cycle pulse per bit on each debounced 1->0 transition of key.
REQ-010 key_event  output  4  sticky press flags; present only with KEYS_EDGE_EN.
REQ-011 key_event_clr  input  4  per-bit clear strobe for key_event (write-1-to-clear source); present only with KEYS_EDGE_EN.

Function
REQ-012 Each of the 14 input bits SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Per bit, while the synchronized value equals the debounced value, the counter SHALL be held at 0.
REQ-014 Per bit, while the synchronized value differs from the debounced value, the counter SHALL increment by one each cycle.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 with the values still differing, the debounced value SHALL take the synchronized value and the counter SHALL return to 0 on that edge.
REQ-016 Any single-cycle return of the synchronized value to the debounced value SHALL reset the counter to 0. A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach key or sw.
REQ-017 Latency: a clean input step SHALL appear on key/sw exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-018 key_press[i] SHALL be 1 for exactly the cycle after key[i] goes from 1 to 0, and 0 otherwise. Releases (0->1) SHALL produce no pulse.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1, so it never wraps.
REQ-020 The bits SHALL be fully independent. Simultaneous changes on several bits SHALL each follow REQ-013..018 with no interaction.

Reset
REQ-021 While preset is 1, synchronizer flops and key SHALL be 1 (released), sw and sw synchronizer flops SHALL be 0, and all counters, key_press and key_event SHALL be 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count. After release, a held level SHALL need a full DEBOUNCE_CYCLES+2 cycles to appear.

Configuration
REQ-023 With macro KEYS_EDGE_EN defined, key_event[i] SHALL set on key_press[i], clear on key_event_clr[i], and otherwise hold. If set and clear occur in the same cycle, set SHALL win.
REQ-024 Without KEYS_EDGE_EN, the key_event and key_event_clr ports and their logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-025 A shared package pk_keys SHALL hold KEY_W=4, SW_W=10 and the default DEBOUNCE_CYCLES constant.
REQ-026 One sub-module, debounce_bit, SHALL implement the synchronizer, counter and debounced register for one bit (parameters DEBOUNCE_CYCLES, CNT_W, RESET_VAL). keys_debounce SHALL instantiate 14 copies of it and add the edge/event logic.

Verification (DEBOUNCE_CYCLES=8, CNT_W=4)
REQ-027 Reset for 3 cycles, then release -> key=4'hF, sw=0, key_press=0, key_event=0.
REQ-028 Drive key_raw[0] 1->0 and hold -> key[0]=0 exactly 10 edges later; key_press[0]=1 for one cycle after that; key_event[0]=1 and stays 1.
REQ-029 Toggle sw_raw[3] with a 5-cycle low pulse, repeated every 6 cycles, for 100 cycles -> sw[3] never changes.
REQ-030 Pulse key_event_clr[0] in the same cycle as a new key_press[0] -> key_event[0] stays 1. Pulse clear alone -> key_event[0]=0 next cycle.
REQ-031 Assert preset for 1 cycle at count 5 of a pending sw_raw[9] 0->1 transition -> sw[9]=0 until 10 edges after reset release.
REQ-032 Change all 14 inputs on the same edge -> all outputs update on the same cycle, 10 edges later. Exactly the pressed keys pulse key_press.

Source files
------------

// File: rtl/keys_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pk_keys (package)
// Description : Shared widths and default timing for the keys/switches
//               debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package pk_keys;

    localparam int KEY_W               = 4;
    localparam int SW_W                = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int CNT_W_DEF           = 16;

    typedef logic [KEY_W-1:0] key_vec_t;
    typedef logic [SW_W-1:0]  sw_vec_t;

endpackage : pk_keys
`default_nettype wire

// File: rtl/keys_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Two-flop synchronizer, stability counter and debounced
//               register for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import pk_keys::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int   CNT_W           = CNT_W_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_level <= RESET_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/keys_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keys_debounce
// Description : Debounces 4 active-low keys and 10 slide switches, generates
//               one-cycle key press pulses. Define KEYS_EDGE_EN to add sticky
//               per-key press flags with write-1-to-clear strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module keys_debounce
    import pk_keys::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [KEY_W-1:0] key_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [KEY_W-1:0] key,
    output logic [SW_W-1:0]  sw,
    output logic [KEY_W-1:0] key_press
`ifdef KEYS_EDGE_EN
    ,
    output logic [KEY_W-1:0] key_event,
    input  logic [KEY_W-1:0] key_event_clr
`endif
);

    key_vec_t r_key_d;
    key_vec_t r_key_press;

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (1'b1)
        ) u_key (
            .clk     (pclk),
            .rst     (preset),
            .i_raw   (key_raw[i]),
            .o_level (key[i])
        );
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (1'b0)
        ) u_sw (
            .clk     (pclk),
            .rst     (preset),
            .i_raw   (sw_raw[i]),
            .o_level (sw[i])
        );
    end

    // Keys are active-low, so a press is a debounced 1->0 edge.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_key_d     <= '1;
            r_key_press <= '0;
        end else begin
            r_key_d     <= key;
            r_key_press <= r_key_d & ~key;
        end
    end

    assign key_press = r_key_press;

`ifdef KEYS_EDGE_EN
    key_vec_t r_key_event;

    // A press arriving with a clear strobe keeps the flag set.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_key_event <= '0;
        end else begin
            r_key_event <= r_key_press | (r_key_event & ~key_event_clr);
        end
    end

    assign key_event = r_key_event;
`endif

endmodule : keys_debounce
`default_nettype wire
